// File: rtl/scope_pkg.sv
// Shared types for the two-channel scope capture block.
// States, the {ch1, ch0} sample word, slope codes and the trigger compare.
package scope_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL_PRE = 3'd1,
    ARMED    = 3'd2,
    POST     = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef struct packed {
    logic [9:0] ch1;
    logic [9:0] ch0;
  } sample_t;

  localparam logic RISING  = 1'b0;
  localparam logic FALLING = 1'b1;

  function automatic logic crossed(
    input logic       slope,
    input logic [9:0] prev,
    input logic [9:0] cur,
    input logic [9:0] level
  );
    if (slope == RISING)
      return (prev < level) && (cur >= level);
    return (prev > level) && (cur <= level);
  endfunction

endpackage

// File: rtl/scope_capture_ram.sv
// Capture RAM: DEPTH x 20 simple dual-port, one write port and
// one registered read port, written to infer block RAM.
module scope_capture_ram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [19:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [19:0]       rdata
);

  logic [19:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rdata <= '0;
    else
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_capture.sv
// Two-channel scope capture: pre-trigger ring, level/slope trigger, frozen record.
// Define SCOPE_AUTO_TRIGGER_EN to force a trigger after AUTO_TIMEOUT armed samples.
module scope_capture
  import scope_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [9:0]        i_data0,
  input  logic [9:0]        i_data1,
  input  logic              i_done,
  input  logic              i_arm,
  input  logic              i_trig_ch,
  input  logic              i_trig_slope,
  input  logic [9:0]        i_trig_level,
  input  logic [ADDR_W-1:0] i_pre_count,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [19:0]       o_rd_data,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] o_trig_addr,
  output logic              o_capture_done,
  output logic              o_auto_trig
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic              done_q;
  logic              s;
  sample_t           w;
  logic [9:0]        cur;
  logic [9:0]        prev;
  logic              prev_valid;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W:0]   post_cnt;
  logic [ADDR_W:0]   post_goal;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] trig_addr;
  logic              capture_done;
  logic              auto_trig;
  logic              hit;
  logic              auto_hit;
  logic              we;
  logic [ADDR_W-1:0] raddr;

  assign s         = i_done & ~done_q;
  assign w.ch1     = i_data1;
  assign w.ch0     = i_data0;
  assign cur       = i_trig_ch ? i_data1 : i_data0;
  assign hit       = prev_valid &&
                     crossed(i_trig_slope, prev, cur, i_trig_level);
  assign post_goal = DEPTH_W - {1'b0, pre_q};
  assign raddr     = trig_addr - pre_q + i_rd_addr;
  assign we        = s && !i_arm &&
                     (state == FILL_PRE || state == ARMED || state == POST);

`ifdef SCOPE_AUTO_TRIGGER_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TO_W-1:0] auto_cnt;

  assign auto_hit = (auto_cnt == TO_W'(AUTO_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_arm)
      auto_cnt <= '0;
    else if (s && state == ARMED)
      auto_cnt <= auto_cnt + 1'b1;
  end
`else
  // No forced trigger in this build; timeout never matures.
  assign auto_hit = (AUTO_TIMEOUT < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      done_q       <= 1'b0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      wptr         <= '0;
      fill_cnt     <= '0;
      post_cnt     <= '0;
      pre_q        <= '0;
      trig_addr    <= '0;
      capture_done <= 1'b0;
      auto_trig    <= 1'b0;
    end else begin
      done_q <= i_done;
      if (i_arm) begin
        pre_q        <= i_pre_count;
        wptr         <= '0;
        fill_cnt     <= '0;
        post_cnt     <= '0;
        prev_valid   <= 1'b0;
        auto_trig    <= 1'b0;
        capture_done <= 1'b0;
        state        <= (i_pre_count != '0) ? FILL_PRE : ARMED;
      end else if (s) begin
        if (we) begin
          prev       <= cur;
          prev_valid <= 1'b1;
          wptr       <= wptr + 1'b1;
        end
        unique case (state)
          FILL_PRE: begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt + 1'b1 == pre_q)
              state <= ARMED;
          end
          ARMED: begin
            if (hit || auto_hit) begin
              trig_addr <= wptr;
              post_cnt  <= {{ADDR_W{1'b0}}, 1'b1};
              auto_trig <= !hit;
              // A one-sample post window completes on the trigger itself.
              if (post_goal == {{ADDR_W{1'b0}}, 1'b1}) begin
                state        <= DONE;
                capture_done <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt + 1'b1 == post_goal) begin
              state        <= DONE;
              capture_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  scope_capture_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (we),
    .waddr (wptr),
    .wdata (w),
    .raddr (raddr),
    .rdata (o_rd_data)
  );

  assign o_state        = state;
  assign o_trig_addr    = trig_addr;
  assign o_capture_done = capture_done;
  assign o_auto_trig    = auto_trig;

endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture (DEPTH 16, AUTO_TIMEOUT 8).
// Records are checked against the bench's own log of samples sent since arm.
module tb_scope_capture;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TO    = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [9:0]    i_data0 = '0;
  logic [9:0]    i_data1 = '0;
  logic          i_done = 1'b0;
  logic          i_arm = 1'b0;
  logic          i_trig_ch = 1'b0;
  logic          i_trig_slope = 1'b0;
  logic [9:0]    i_trig_level = '0;
  logic [AW-1:0] i_pre_count = '0;
  logic [AW-1:0] i_rd_addr = '0;
  logic [19:0]   o_rd_data;
  logic [2:0]    o_state;
  logic [AW-1:0] o_trig_addr;
  logic          o_capture_done;
  logic          o_auto_trig;

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] hist[$];
  logic [19:0] exp_q[$];

  scope_capture #(
    .DEPTH        (DEPTH),
    .AUTO_TIMEOUT (TO)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_data0        (i_data0),
    .i_data1        (i_data1),
    .i_done         (i_done),
    .i_arm          (i_arm),
    .i_trig_ch      (i_trig_ch),
    .i_trig_slope   (i_trig_slope),
    .i_trig_level   (i_trig_level),
    .i_pre_count    (i_pre_count),
    .i_rd_addr      (i_rd_addr),
    .o_rd_data      (o_rd_data),
    .o_state        (o_state),
    .o_trig_addr    (o_trig_addr),
    .o_capture_done (o_capture_done),
    .o_auto_trig    (o_auto_trig)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic arm(input int pre);
    i_pre_count = AW'(pre);
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
    hist.delete();
  endtask

  task automatic arm_with_sample(input int pre, input int d0, input int d1);
    i_pre_count = AW'(pre);
    i_data0 = 10'(d0);
    i_data1 = 10'(d1);
    i_arm = 1'b1;
    i_done = 1'b1;
    tick();
    i_arm = 1'b0;
    i_done = 1'b0;
    hist.delete();
    tick();
  endtask

  task automatic smp(input int d0, input int d1);
    i_data0 = 10'(d0);
    i_data1 = 10'(d1);
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    hist.push_back({10'(d1), 10'(d0)});
    tick();
  endtask

  task automatic read_record(input string tag, input int trig_idx,
                             input int pre);
    for (int a = 0; a < DEPTH; a++) begin
      i_rd_addr = AW'(a);
      exp_q.push_back(hist[trig_idx - pre + a]);
      tick();
      check($sformatf("%s[%0d]", tag, a), o_rd_data, exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and idle behaviour
    tick();
    tick();
    check("rst_state", o_state, 0);
    check("rst_trig", o_trig_addr, 0);
    check("rst_rd", o_rd_data, 0);
    check("rst_done", o_capture_done, 0);
    check("rst_auto", o_auto_trig, 0);
    i_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) smp(i + 1, i + 2);
    check("idle_hold", o_state, 0);

    // rising ch0 ramp, pre 4
    i_trig_ch = 1'b0;
    i_trig_slope = 1'b0;
    i_trig_level = 10'd55;
    arm(4);
    check("t2_arm", o_state, 1);
    for (int i = 0; i < 18; i++) begin
      smp(10 * i, 500 + i);
      if (i == 3) check("t2_armed", o_state, 2);
      if (i == 6) check("t2_post", o_state, 3);
      if (i == 6) check("t2_trig", o_trig_addr, 6);
      if (i == 16) check("t2_not_done", o_state, 3);
    end
    check("t2_done", o_state, 4);
    check("t2_cdone", o_capture_done, 1);
    check("t2_auto", o_auto_trig, 0);
    smp(1, 1);
    smp(2, 2);
    check("t2_frozen", o_state, 4);
    read_record("t2_rd", 6, 4);

    // falling on ch1 with ring wrap while armed, pre 5
    i_trig_ch = 1'b1;
    i_trig_slope = 1'b1;
    i_trig_level = 10'd500;
    arm(5);
    for (int i = 0; i < 46; i++) begin
      smp(i < 20 ? 600 + i : 100 + i, i < 35 ? 700 + i : 300 + i);
      if (i == 34) check("t3_armed", o_state, 2);
      if (i == 35) check("t3_post", o_state, 3);
      if (i == 35) check("t3_trig", o_trig_addr, (35 % DEPTH));
    end
    check("t3_done", o_state, 4);
    read_record("t3_rd", 35, 5);

    // pre 0: first sample only loads prev
    i_trig_ch = 1'b0;
    i_trig_slope = 1'b0;
    i_trig_level = 10'd400;
    arm(0);
    check("t4_arm", o_state, 2);
    smp(450, 0);
    check("t4_s0", o_state, 2);
    smp(50, 1);
    check("t4_s1", o_state, 2);
    smp(450, 2);
    check("t4_s2", o_state, 3);
    check("t4_trig", o_trig_addr, 2);
    for (int i = 3; i < 18; i++) smp(500 + i, i);
    check("t4_done", o_state, 4);
    read_record("t4_rd", 2, 0);

    // re-arm during POST, arm coincident with a sample
    i_trig_level = 10'd55;
    arm(3);
    for (int i = 0; i < 10; i++) smp(10 * i, 100 + i);
    check("t5_post", o_state, 3);
    arm_with_sample(2, 1000, 1000);
    check("t5_rearm", o_state, 1);
    for (int i = 0; i < 19; i++) begin
      smp(5 + 10 * i, 900 - i);
      if (i == 5) check("t5_trig", o_trig_addr, 5);
      if (i == 17) check("t5_not_done", o_state, 3);
    end
    check("t5_done", o_state, 4);
    read_record("t5_rd", 5, 2);

    // constant input: auto trigger only when built in
    i_trig_level = 10'd500;
    arm(0);
`ifdef SCOPE_AUTO_TRIGGER_EN
    for (int i = 0; i < TO - 1; i++) smp(100, 100);
    check("t6_armed", o_state, 2);
    smp(100, 100);
    check("t6_post", o_state, 3);
    check("t6_trig", o_trig_addr, TO - 1);
    check("t6_auto", o_auto_trig, 1);
    for (int i = 0; i < DEPTH - 1; i++) smp(100, 100);
    check("t6_done", o_state, 4);
    check("t6_auto_keep", o_auto_trig, 1);
`else
    for (int i = 0; i < 100; i++) smp(100, 100);
    check("t6_armed", o_state, 2);
    check("t6_auto", o_auto_trig, 0);
    check("t6_cdone", o_capture_done, 0);
`endif

    // reset mid-capture
    i_trig_level = 10'd55;
    arm(2);
    smp(0, 0);
    i_rst_n = 1'b0;
    tick();
    check("t7_state", o_state, 0);
    check("t7_trig", o_trig_addr, 0);
    check("t7_rd", o_rd_data, 0);
    check("t7_cdone", o_capture_done, 0);
    i_rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
